// File: rtl/branch_pc_unit_if.sv
// Control, comparator and status signals of the branch/PC stage.
// master = the decode/fetch side driving controls, slave = branch_pc_unit.
interface branch_pc_unit_if;
   logic        advance;
   logic        stall;
   logic        branch;
   logic        jump;
   logic        jalr;
   logic [2:0]  funct3;
   logic [31:0] target;
   logic        BrEq;
   logic        BrLT;
   logic        BrUn;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        pc_valid;
   logic        taken;
   logic        halted;
   logic        misalign_err;
   logic        illegal_err;
   logic        cnt_clr;
   logic [31:0] br_cnt;
   logic [31:0] br_taken_cnt;
   logic [1:0]  state_dbg;

   modport master (
      output advance, stall, branch, jump, jalr, funct3, target, BrEq, BrLT, cnt_clr,
      input  BrUn, pc, pc_plus4, pc_valid, taken, halted, misalign_err, illegal_err,
             br_cnt, br_taken_cnt, state_dbg
   );

   modport slave (
      input  advance, stall, branch, jump, jalr, funct3, target, BrEq, BrLT, cnt_clr,
      output BrUn, pc, pc_plus4, pc_valid, taken, halted, misalign_err, illegal_err,
             br_cnt, br_taken_cnt, state_dbg
   );
endinterface

// File: rtl/branch_pc_unit.sv
// PC stage after the branch comparator: resolves taken/not-taken, registers the
// next PC, halts on misaligned/illegal transfers, and counts conditional branches.
module branch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic              clk,
   input logic              rst_n,
   branch_pc_unit_if.slave  bus
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] br_cnt_q, br_cnt_d;
   logic [31:0] br_taken_cnt_q, br_taken_cnt_d;
   logic        misalign_q, misalign_d;
   logic        illegal_q, illegal_d;

   logic        cond;
   logic        legal;
   logic        taken;
   logic        retire;
   logic        count_en;
   logic [31:0] eff_target;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;

   always_comb begin
      cond = 1'b0;
      case (bus.funct3)
         3'b000:          cond = bus.BrEq;
         3'b001:          cond = !bus.BrEq;
         3'b100, 3'b110:  cond = bus.BrLT;
         3'b101, 3'b111:  cond = !bus.BrLT;
         default:         cond = 1'b0;
      endcase
   end

   assign legal      = (bus.funct3[2:1] != 2'b01);
   assign taken      = bus.jump | (bus.branch & cond);
   assign retire     = bus.advance & !bus.stall;
   assign eff_target = bus.jalr ? {bus.target[31:1], 1'b0} : bus.target;
   assign pc_plus4   = pc_q + 32'd4;
   assign next_pc    = taken ? eff_target : pc_plus4;

   // A faulting transfer leaves pc pointing at the offending instruction.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      misalign_d = misalign_q;
      illegal_d  = illegal_q;
      count_en   = 1'b0;
      case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (retire) begin
               count_en = bus.branch & !bus.jump & legal;
               if (taken && (eff_target[1:0] != 2'b00)) begin
                  state_d    = HALT;
                  misalign_d = 1'b1;
               end else if (bus.branch && !bus.jump && !legal) begin
                  state_d   = HALT;
                  illegal_d = 1'b1;
               end else begin
                  pc_d = next_pc;
               end
            end
         end
         HALT: state_d = HALT;
         default: state_d = BOOT;
      endcase
   end

   always_comb begin
      br_cnt_d       = br_cnt_q;
      br_taken_cnt_d = br_taken_cnt_q;
      if (bus.cnt_clr) begin
         br_cnt_d       = 32'd0;
         br_taken_cnt_d = 32'd0;
      end else if (count_en) begin
         if (br_cnt_q != 32'hFFFF_FFFF) br_cnt_d = br_cnt_q + 32'd1;
         if (cond && (br_taken_cnt_q != 32'hFFFF_FFFF)) br_taken_cnt_d = br_taken_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= BOOT;
         pc_q           <= RESET_PC;
         misalign_q     <= 1'b0;
         illegal_q      <= 1'b0;
         br_cnt_q       <= 32'd0;
         br_taken_cnt_q <= 32'd0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         misalign_q     <= misalign_d;
         illegal_q      <= illegal_d;
         br_cnt_q       <= br_cnt_d;
         br_taken_cnt_q <= br_taken_cnt_d;
      end
   end

   assign bus.BrUn         = bus.funct3[1];
   assign bus.taken        = taken;
   assign bus.pc           = pc_q;
   assign bus.pc_plus4     = pc_plus4;
   assign bus.pc_valid     = (state_q == RUN);
   assign bus.halted       = (state_q == HALT);
   assign bus.misalign_err = misalign_q;
   assign bus.illegal_err  = illegal_q;
   assign bus.br_cnt       = br_cnt_q;
   assign bus.br_taken_cnt = br_taken_cnt_q;
   assign bus.state_dbg    = state_q;

endmodule
